slt_seq_cmp: RTL

//  Parametrised multi-cycle set-less-than unit for the ALU compare path.

---
 rtl/slt_seq_cmp.sv | 111 +++++++++++
 1 files changed

// File: rtl/slt_seq_cmp.sv
// Multi-cycle set-less-than unit: MSB-first chunked compare with early exit.
// Signed mode flips operand sign bits so every chunk compare is unsigned.
module slt_seq_cmp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int NCYC = WIDTH / CHUNK;
    localparam int IDXW = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [WIDTH-1:0] SMASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCYC - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("slt_seq_cmp: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;

    always_comb begin
        a_ch = a_r[idx*CHUNK +: CHUNK];
        b_ch = b_r[idx*CHUNK +: CHUNK];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Offset-binary mapping turns signed order into unsigned order
                        a_r      <= is_signed ? (a ^ SMASK) : a;
                        b_r      <= is_signed ? (b ^ SMASK) : b;
                        idx      <= IDX_TOP;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (a_ch != b_ch) begin
                        lt        <= (a_ch < b_ch);
                        eq        <= 1'b0;
                        result    <= {{(WIDTH-1){1'b0}}, (a_ch < b_ch)};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        lt        <= 1'b0;
                        eq        <= 1'b1;
                        result    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
